// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle add/sub/mul/div sequencer; divider compiled in only when CALC_SEQ_DIV_EN is defined
module calc_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic        ovr_o,
  output logic        neg_o,
  output logic        zero_o,
  output logic        divzero_o
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] res_q, res_d;
  logic        ovr_q, ovr_d, neg_q, neg_d, zero_q, zero_d, dz_q, dz_d;
  logic [7:0]  sum;
  logic [15:0] iter;
  logic [3:0]  last;
  logic        is_dz;
  logic        div_ovr;
`ifdef CALC_SEQ_DIV_EN
  logic [16:0] div_sh;
  logic [7:0]  div_rem;
  // one restoring-division step over {remainder, dividend/quotient}
  always_comb begin
    div_sh  = {acc_q, 1'b0};
    div_rem = div_sh[15:8] - b_q;
  end
  assign is_dz   = (op_q == OP_DIV) && (b_q == 8'h00);
  assign div_ovr = 1'b0;
  assign last    = (op_q == OP_MUL || (op_q == OP_DIV && !is_dz)) ? 4'd8 : 4'd1;
`else
  assign is_dz   = 1'b0;
  assign div_ovr = 1'b1;
  assign last    = (op_q == OP_MUL) ? 4'd8 : 4'd1;
`endif
  // datapath value produced by one EXEC iteration of the captured operation
  always_comb begin
    sum  = op_q[0] ? a_q[7:0] - b_q : a_q[7:0] + b_q;
    iter = {{8{sum[7]}}, sum};
    if (op_q == OP_MUL) iter = acc_q + (b_q[0] ? a_q : 16'h0000);
`ifdef CALC_SEQ_DIV_EN
    if (op_q == OP_DIV) iter = is_dz ? {a_q[7:0], 8'hFF} : (div_sh[16:8] >= {1'b0, b_q}) ? {div_rem, div_sh[7:1], 1'b1} : div_sh[15:0];
`else
    if (op_q == OP_DIV) iter = 16'h0000;
`endif
  end
  // next-state, operand capture, iteration and result commit on entry to DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ovr_d   = ovr_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = EXEC;
        cnt_d   = 4'd0;
        op_d    = op_i;
        a_d     = {8'h00, a_i};
        b_d     = b_i;
        acc_d   = (op_i == OP_DIV) ? {8'h00, a_i} : 16'h0000;
      end
      EXEC: if (cnt_q == last) begin
        state_d = DONE;
        res_d   = acc_q;
        ovr_d   = (op_q == OP_ADD) ? (a_q[7] == b_q[7]) && (acc_q[7] != a_q[7]) :
                  (op_q == OP_SUB) ? (a_q[7] != b_q[7]) && (acc_q[7] != a_q[7]) :
                  (op_q == OP_MUL) ? |acc_q[15:8] : div_ovr;
        neg_d   = !op_q[1] && acc_q[7];
        zero_d  = (acc_q == 16'h0000) && !(op_q == OP_DIV && div_ovr);
        dz_d    = is_dz;
      end else begin
        cnt_d = cnt_q + 4'd1;
        acc_d = iter;
        a_d   = (op_q == OP_MUL) ? {a_q[14:0], 1'b0} : a_q;
        b_d   = (op_q == OP_MUL) ? {1'b0, b_q[7:1]} : b_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'b00;
      a_q     <= 16'h0000;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
      res_q   <= 16'h0000;
      ovr_q   <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ovr_q   <= ovr_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
    end
  end
  assign busy_o    = state_q != IDLE;
  assign done_o    = state_q == DONE;
  assign result_o  = res_q;
  assign ovr_o     = ovr_q;
  assign neg_o     = neg_q;
  assign zero_o    = zero_q;
  assign divzero_o = dz_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed vectors with literal expectations plus a per-cycle behavioural model check
`timescale 1ns/1ps
module tb_calc_sequencer;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic busy, done, ovr, neg, zero, dz;
  logic [15:0] result;
  int total = 0, bad = 0;
  bit run_chk = 0;
  calc_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result),
    .ovr_o(ovr), .neg_o(neg), .zero_o(zero), .divzero_o(dz)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [15:0] r; logic o; logic n; logic z; logic d;} res_t;
  typedef struct {logic [1:0] op; logic [7:0] a; logic [7:0] b; res_t e; int lat; int poke;} vec_t;
  // expected outputs straight from the arithmetic rules
  function automatic res_t expect_of(input logic [1:0] f, input logic [7:0] x, input logic [7:0] y);
    res_t e;
    int s;
    logic [7:0] w;
    e = '0;
    if (f == 2'b00 || f == 2'b01) begin
      s = f[0] ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
      w = 8'(s);
      e.r = {{8{w[7]}}, w};
      e.o = (s > 127) || (s < -128);
      e.n = w[7];
    end else if (f == 2'b10) begin
      s = int'(x) * int'(y);
      e.r = 16'(s);
      e.o = s > 255;
    end else begin
`ifdef CALC_SEQ_DIV_EN
      if (y == 8'h00) begin
        e.r = {x, 8'hFF};
        e.d = 1'b1;
      end else e.r = {x % y, x / y};
`else
      e.o = 1'b1;
`endif
    end
    e.z = (e.r == 16'h0000);
`ifndef CALC_SEQ_DIV_EN
    if (f == 2'b11) e.z = 1'b0;
`endif
    return e;
  endfunction
  function automatic int lat_of(input logic [1:0] f, input logic [7:0] y);
`ifdef CALC_SEQ_DIV_EN
    return (f == 2'b10 || (f == 2'b11 && y != 8'h00)) ? 9 : 2;
`else
    if (y == 8'hxx) return 0;
    return (f == 2'b10) ? 9 : 2;
`endif
  endfunction
  res_t m_out = '0, m_pend = '0;
  bit m_busy = 0, m_done = 0;
  int m_k = 0, m_lat = 0;
  // model: count edges since the accepted start and publish results at the latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = '0;
      m_busy = 0;
      m_done = 0;
      m_k = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_k = 0;
          m_pend = expect_of(op, a, b);
          m_lat = lat_of(op, b);
        end
      end else begin
        m_k++;
        if (m_k == m_lat) begin
          m_done = 1;
          m_out = m_pend;
        end else if (m_k == m_lat + 1) m_busy = 0;
      end
    end
  end
  // every cycle out of reset the DUT must match the model
  always @(negedge clk) begin
    if (run_chk && !rst) begin
      total++;
      if ({busy, done, result, ovr, neg, zero, dz} !== {m_busy, m_done, m_out}) begin
        bad++;
        $display("FAIL cycle t=%0t: busy/done/result/ovr,neg,zero,dz got %b/%b/%h/%b%b%b%b want %b/%b/%h/%b%b%b%b", $time,
                 busy, done, result, ovr, neg, zero, dz, m_busy, m_done, m_out.r, m_out.o, m_out.n, m_out.z, m_out.d);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    op = v.op;
    a = v.a;
    b = v.b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0;
    seen = 0;
    while (n < 20 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (n == v.poke - 1) start = 1'b1;
      else if (n == v.poke) start = 1'b0;
      seen = done;
    end
    if (!seen) begin
      bad++;
      total++;
      $display("FAIL done_timeout: op=%0d got no done want done", v.op);
      return;
    end
    chk("latency", n, v.lat);
    chk("result", {16'h0, result}, {16'h0, v.e.r});
    chk("flags_ovr_neg_zero_dz", {ovr, neg, zero, dz}, {v.e.o, v.e.n, v.e.z, v.e.d});
    start = 1'b1;
    op = 2'b00;
    a = 8'h01;
    b = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_in_done_ignored", {busy, done}, 2'b00);
  endtask
  vec_t vq[$];
  function automatic vec_t mk(input logic [1:0] f, input logic [7:0] x, input logic [7:0] y, input logic [15:0] r,
                              input logic o, input logic n, input logic z, input logic d, input int lat, input int poke);
    vec_t v;
    v.op = f; v.a = x; v.b = y; v.e = {r, o, n, z, d}; v.lat = lat; v.poke = poke;
    return v;
  endfunction
  initial begin
    vq.push_back(mk(2'b00, 8'h7F, 8'h01, 16'hFF80, 1, 1, 0, 0, 2, 0));
    vq.push_back(mk(2'b01, 8'h05, 8'h05, 16'h0000, 0, 0, 1, 0, 2, 0));
    vq.push_back(mk(2'b10, 8'hFF, 8'hFF, 16'hFE01, 1, 0, 0, 0, 9, 4));
    vq.push_back(mk(2'b01, 8'h80, 8'h01, 16'h007F, 1, 0, 0, 0, 2, 0));
    vq.push_back(mk(2'b00, 8'hFF, 8'hFF, 16'hFFFE, 0, 1, 0, 0, 2, 0));
    vq.push_back(mk(2'b10, 8'h10, 8'h0F, 16'h00F0, 0, 0, 0, 0, 9, 0));
    vq.push_back(mk(2'b10, 8'h00, 8'h5A, 16'h0000, 0, 0, 1, 0, 9, 0));
`ifdef CALC_SEQ_DIV_EN
    vq.push_back(mk(2'b11, 8'd200, 8'd7, 16'h041C, 0, 0, 0, 0, 9, 0));
    vq.push_back(mk(2'b11, 8'h37, 8'h00, 16'h37FF, 0, 0, 0, 1, 2, 0));
    vq.push_back(mk(2'b11, 8'h05, 8'h09, 16'h0500, 0, 0, 0, 0, 9, 0));
`else
    vq.push_back(mk(2'b11, 8'h09, 8'h03, 16'h0000, 1, 0, 0, 0, 2, 0));
`endif
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", {busy, done, result, ovr, neg, zero, dz}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_chk = 1;
    foreach (vq[i]) run(vq[i]);
    @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    a = 8'hFF;
    b = 8'h0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_reset_outputs", {busy, done, result, ovr, neg, zero, dz}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
    end
    run(mk(2'b00, 8'h01, 8'h02, 16'h0003, 0, 0, 0, 0, 2, 0));
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001: Clock  in  1  single system clock; all state updates on the rising edge.
REQ-002: Reset  in  1  asynchronous, active-high reset.
REQ-003: Start  in  1  request pulse; sampled only while Busy=0.
REQ-004: Op  in  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
REQ-005: A  in  8  operand A (dividend for div).
REQ-006: B  in  8  operand B (divisor for div).
REQ-007: Busy  out  1  high in EXEC and DONE states.
REQ-008: Done  out  1  one-cycle completion pulse.
REQ-009: Result  out  16  operation result, held until the next accepted Start.
REQ-010: OVR, NEG, ZERO  out  1 each  condition codes, valid with Done and held with Result.
REQ-011: DivZero  out  1  divide-by-zero indication, held with Result.

Function
REQ-012: The state machine SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-013: In IDLE, when Start=1 at a rising edge, the block SHALL capture A, B and Op, clear the iteration counter, and enter EXEC.
REQ-014: Start SHALL be ignored whenever Busy=1, and Op/A/B changes after capture SHALL have no effect.
REQ-015: Add and sub SHALL complete in one EXEC cycle using signed 8-bit arithmetic.
  - Result = sign-extended 8-bit sum/difference.
  - OVR = signed overflow.
  - NEG = Result[7].
REQ-016: Mul SHALL be unsigned shift-add over 8 EXEC cycles.
  - Result = full 16-bit product.
  - OVR = (Result[15:8] != 0).
  - NEG = 0.
REQ-017: Div SHALL be unsigned restoring division over 8 EXEC cycles.
  - Result = {remainder, quotient}.
  - OVR = 0, NEG = 0.
REQ-018: Div with B=0 SHALL leave EXEC after one cycle.
  - Result = {A, 8'hFF}, DivZero = 1, OVR = 0.
REQ-019: ZERO SHALL equal (Result == 0) for every operation.
REQ-020: DivZero SHALL be 0 for every operation except REQ-018.
REQ-021: EXEC SHALL go to DONE after its final iteration; DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-022: Latency, with Start accepted at edge 0:
  - Done=1 after edge 2 for add, sub and div-by-zero.
  - Done=1 after edge 9 for mul and div.
REQ-023: Result and flags SHALL update only on entry to DONE and SHALL remain stable through IDLE.
REQ-024: A Start asserted in the cycle where Done=1 SHALL be ignored; the earliest accepted Start is the cycle after Done.

Reset
REQ-025: While Reset=1, independent of Clock, the block SHALL force:
  - state = IDLE, iteration counter = 0;
  - Busy = 0, Done = 0, Result = 16'h0000;
  - OVR = NEG = ZERO = DivZero = 0.
REQ-026: Reset asserted mid-operation SHALL abort it with no Done pulse; the first accepted Start after reset release SHALL run normally.

Configuration
REQ-027: Macro CALC_SEQ_DIV_EN SHALL compile the divider (REQ-017, REQ-018) in when defined.
REQ-028: When CALC_SEQ_DIV_EN is undefined, Op=11 SHALL complete with add/sub latency.
  - Result = 0, OVR = 1, ZERO = 0, NEG = 0, DivZero = 0.
  - No divider logic SHALL be synthesized.

Verification
REQ-029: Op=00, A=0x7F, B=0x01 -> Result=0xFF80, OVR=1, NEG=1, ZERO=0, Done after edge 2.
REQ-030: Op=01, A=0x05, B=0x05 -> Result=0x0000, ZERO=1, OVR=0, NEG=0.
REQ-031: Op=10, A=0xFF, B=0xFF -> Result=0xFE01, OVR=1, Done after edge 9; Start pulsed at edge 4 is ignored.
REQ-032: Op=11, A=200, B=7 -> Result=0x041C, DivZero=0; with B=0, A=0x37 -> Result=0x37FF, DivZero=1, Done after edge 2.
REQ-033: Reset pulsed during mul iteration 4 -> all outputs 0 immediately, no Done; next Start Op=00, A=1, B=2 -> Result=0x0003.
REQ-034: Build without CALC_SEQ_DIV_EN, Op=11, A=9, B=3 -> Result=0x0000, OVR=1, Done after edge 2.
